// File: rtl/car_spawner.sv
// Lane-based car spawner: every frame tick draws one lane, blocks it for MIN_GAP ticks, and issues a valid/ready spawn request.
// Optional statistics counters are built when the macro SPAWN_STATS_EN is defined.
module car_spawner #(
  parameter int MIN_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_active,
  input  logic       tick,
  input  logic [3:0] rand_val,
  output logic [2:0] sel_out,
  output logic       spawn_valid,
  input  logic       spawn_ready,
  output logic [2:0] spawn_lane,
  output logic [1:0] spawn_speed,
  output logic [7:0] spawn_cnt,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAW, ISSUE} state_t;

  localparam logic [3:0] GAP = 4'(MIN_GAP);

  state_t     state_q, state_d;
  logic [2:0] lane_ptr_q, lane_ptr_d;
  logic [3:0] cooldown_q [8];
  logic [3:0] cooldown_d [8];
  logic       valid_q, valid_d;
  logic [2:0] lane_q, lane_d;
  logic [1:0] speed_q, speed_d;

  // Only the spawn flag and the speed field of the random value are meaningful.
  logic unused_rand_bit;
  assign unused_rand_bit = rand_val[2];

  always_comb begin
    state_d    = state_q;
    lane_ptr_d = lane_ptr_q;
    valid_d    = valid_q;
    lane_d     = lane_q;
    speed_d    = speed_q;
    for (int i = 0; i < 8; i++) cooldown_d[i] = cooldown_q[i];

    if (!game_active) begin
      state_d    = IDLE;
      lane_ptr_d = 3'd0;
      valid_d    = 1'b0;
      for (int i = 0; i < 8; i++) cooldown_d[i] = 4'd0;
    end else begin
      if (tick && state_q != IDLE) begin
        for (int i = 0; i < 8; i++)
          if (cooldown_q[i] != 4'd0) cooldown_d[i] = cooldown_q[i] - 4'd1;
      end
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: if (tick) state_d = DRAW;
        DRAW: begin
          lane_ptr_d = lane_ptr_q + 3'd1;
          // The blocking test uses the cooldown before this cycle's decrement; the load wins over it.
          if (cooldown_q[lane_ptr_q] == 4'd0 && rand_val[3]) begin
            lane_d                 = lane_ptr_q;
            speed_d                = (rand_val[1:0] == 2'd0) ? 2'd1 : rand_val[1:0];
            cooldown_d[lane_ptr_q] = GAP;
            valid_d                = 1'b1;
            state_d                = ISSUE;
          end else begin
            state_d = WAIT;
          end
        end
        ISSUE: if (spawn_ready) begin
          valid_d = 1'b0;
          state_d = WAIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      lane_ptr_q <= 3'd0;
      valid_q    <= 1'b0;
      lane_q     <= 3'd0;
      speed_q    <= 2'd0;
      for (int i = 0; i < 8; i++) cooldown_q[i] <= 4'd0;
    end else begin
      state_q    <= state_d;
      lane_ptr_q <= lane_ptr_d;
      valid_q    <= valid_d;
      lane_q     <= lane_d;
      speed_q    <= speed_d;
      for (int i = 0; i < 8; i++) cooldown_q[i] <= cooldown_d[i];
    end
  end

  assign sel_out     = lane_ptr_q;
  assign spawn_valid = valid_q;
  assign spawn_lane  = lane_q;
  assign spawn_speed = speed_q;

`ifdef SPAWN_STATS_EN
  logic [7:0] spawn_cnt_q, spawn_cnt_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    spawn_cnt_d = spawn_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (game_active) begin
      if (state_q == ISSUE && spawn_ready && spawn_cnt_q != 8'hFF)
        spawn_cnt_d = spawn_cnt_q + 8'd1;
      // Ticks arriving while a draw is in flight are lost frames.
      if (tick && (state_q == DRAW || state_q == ISSUE) && drop_cnt_q != 8'hFF)
        drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      spawn_cnt_q <= 8'd0;
      drop_cnt_q  <= 8'd0;
    end else begin
      spawn_cnt_q <= spawn_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign spawn_cnt = spawn_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  assign spawn_cnt = 8'd0;
  assign drop_cnt  = 8'd0;
`endif

endmodule

// File: doc/car_spawner.md
CAR_SPAWNER -- requirements
Module: car_spawner

Interface
REQ-001 SHALL have parameter MIN_GAP, default 4, frame ticks a lane stays blocked after a spawn (legal 1..15).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous active-low reset, sampled on posedge clk.
REQ-004 SHALL have port game_active  input  1  high while play is running; low forces idle.
REQ-005 SHALL have port tick  input  1  one-cycle frame pulse.
REQ-006 SHALL have port rand_val  input  4  value from the upstream random generator.
REQ-007 SHALL have port sel_out  output  3  selector to the random generator's 3-bit mode input; always equals lane_ptr.
REQ-008 SHALL have port spawn_valid  output  1  spawn request valid.
REQ-009 SHALL have port spawn_ready  input  1  consumer accepts the spawn when high with spawn_valid.
REQ-010 SHALL have port spawn_lane  output  3  lane index of the request.
REQ-011 SHALL have port spawn_speed  output  2  car speed of the request, 1..3.
REQ-012 SHALL have port spawn_cnt  output  8  accepted-spawn count (see Configuration).
REQ-013 SHALL have port drop_cnt  output  8  missed-draw count (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, DRAW, ISSUE.
REQ-015 SHALL keep 3-bit lane_ptr and eight 4-bit cooldown counters, one per lane.
REQ-016 IDLE: when game_active=1, go to WAIT next cycle; otherwise stay.
REQ-017 WAIT: on tick=1, go to DRAW next cycle.
REQ-018 On every tick outside IDLE, each nonzero cooldown SHALL decrement by 1; zero cooldowns stay at 0.
REQ-019 DRAW: if cooldown[lane_ptr]==0 (pre-decrement value) and rand_val[3]==1, SHALL latch spawn_lane=lane_ptr and spawn_speed=rand_val[1:0] (0 coerced to 1), load cooldown[lane_ptr]=MIN_GAP, and go to ISSUE; otherwise go to WAIT.
REQ-020 Load of MIN_GAP SHALL take priority over a simultaneous tick decrement on the same lane.
REQ-021 On leaving DRAW, lane_ptr SHALL increment, wrapping 7 to 0.
REQ-022 ISSUE: spawn_valid=1; spawn_lane and spawn_speed SHALL hold stable until a handshake completes.
REQ-023 spawn_valid SHALL assert exactly 2 cycles after the tick that entered DRAW, with no wait states.
REQ-024 A handshake (spawn_valid and spawn_ready high together) SHALL return the FSM to WAIT next cycle; spawn_valid is then 0.
REQ-025 A tick arriving in DRAW or ISSUE SHALL NOT start a new draw; it still decrements cooldowns per REQ-018.
REQ-026 game_active=0 in any state SHALL move to IDLE next cycle, drop spawn_valid, clear all cooldowns, and set lane_ptr=0.

Reset
REQ-027 On rst=0 at posedge clk, SHALL enter IDLE and clear lane_ptr, sel_out, all cooldowns, spawn_valid, spawn_lane, spawn_speed, spawn_cnt and drop_cnt to 0.
REQ-028 Reset SHALL override every other input, including during ISSUE.

Configuration
REQ-029 Macro SPAWN_STATS_EN defined: spawn_cnt increments on each handshake; drop_cnt increments on each tick seen in DRAW or ISSUE; both saturate at 255 and clear only on reset.
REQ-030 Macro SPAWN_STATS_EN undefined: spawn_cnt and drop_cnt SHALL be constant 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-031 rst=0 for 2 cycles -> all outputs 0, FSM in IDLE.
REQ-032 game_active=1, rand_val=4'b1010, spawn_ready=1, tick pulse -> spawn_valid high for exactly 1 cycle, 2 cycles after tick, with lane 0 and speed 2; sel_out then reads 1.
REQ-033 rand_val=4'b1000 -> speed 1; rand_val=4'b0111 -> no spawn, and lane_ptr still advances.
REQ-034 spawn_ready=0 for 6 cycles with 2 ticks in that window -> spawn_valid, lane and speed stay stable, cooldowns decrement by 2, and drop_cnt=2 (macro on) or 0 (macro off).
REQ-035 MIN_GAP=15, rand_val fixed at 4'b1001, 8 draws -> on its second visit lane 0 has a nonzero cooldown and does not spawn.
REQ-036 game_active dropped during ISSUE -> spawn_valid=0 next cycle, FSM in IDLE, cooldowns 0, and sel_out=0.
